// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 constants, instruction classes and fetch FSM states
package mips32_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0a;
    localparam logic [5:0] OP_SUBI  = 6'h0b;
    localparam logic [5:0] OP_SLTI  = 6'h0c;
    localparam logic [5:0] OP_BNEQZ = 6'h0d;
    localparam logic [5:0] OP_BEQZ  = 6'h0e;
    localparam logic [5:0] OP_HLT   = 6'h3f;

    typedef enum logic [2:0] {
        IT_RR_ALU,
        IT_RM_ALU,
        IT_LOAD,
        IT_STORE,
        IT_BRANCH,
        IT_HALT
    } instr_type_e;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_e;

    function automatic instr_type_e classify(input logic [5:0] op);
        instr_type_e t;
        t = IT_RR_ALU;
        case (op)
            OP_ADDI, OP_SUBI, OP_SLTI: t = IT_RM_ALU;
            OP_LW:                     t = IT_LOAD;
            OP_SW:                     t = IT_STORE;
            OP_BNEQZ, OP_BEQZ:         t = IT_BRANCH;
            OP_HLT:                    t = IT_HALT;
            default:                   t = IT_RR_ALU;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// rtl/mips32_fetch_fifo.sv - DEPTH-entry synchronous FIFO holding {instruction, next pc}
// Flush wins over push and pop; the head entry is read combinationally.
module mips32_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !flush && (count_q != DEPTH_C);
    assign do_pop  = pop  && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - instruction fetch unit: pc, one-outstanding request FSM, fetch queue
// A queue slot is reserved at issue, so a returning response can always be pushed.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_ir,
    output logic [WORD_W-1:0] out_npc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e        state_q, state_d;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]       count;
    logic [2*WORD_W-1:0] head;
    logic                issue, accept, pop;

    // Issue depends only on state and level inputs, never on imem_rvalid.
    assign issue  = rst_n && (state_q == FS_IDLE) && !halt && !redirect_valid && (count < DEPTH_C);
    assign accept = (state_q == FS_WAIT) && imem_rvalid && !redirect_valid;
    assign pop    = out_valid && out_ready && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FS_IDLE: if (issue) state_d = FS_WAIT;
            FS_WAIT: begin
                if (imem_rvalid)         state_d = FS_IDLE;
                else if (redirect_valid) state_d = FS_DROP;
            end
            FS_DROP: if (imem_rvalid) state_d = FS_IDLE;
            default: state_d = FS_IDLE;
        endcase
        if (redirect_valid)  pc_d = redirect_pc;
        else if (issue)      pc_d = pc_q + 32'd1;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // While WAIT, pc_q already holds fetch address + 1, which is the entry's npc.
    mips32_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD_W)
    ) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data ({imem_rdata, pc_q}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (count)
    );

    assign imem_req  = issue;
    assign imem_addr = issue ? pc_q : '0;
    assign out_valid = (count != '0);
    assign out_ir    = head[2*WORD_W-1:WORD_W];
    assign out_npc   = head[WORD_W-1:0];

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4; queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0; first fetch word address after reset.
REQ-003 clk1  in  1  sole clock; all state updates on posedge clk1.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 redirect_valid  in  1  taken branch; flush and refetch from redirect_pc.
REQ-006 redirect_pc  in  32  branch target word address.
REQ-007 halt  in  1  level; while high, no new memory requests are issued.
REQ-008 imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-009 imem_addr  out  32  word address, valid while imem_req=1.
REQ-010 imem_rvalid  in  1  one-cycle response strobe, exactly one per request.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-012 out_valid  out  1  head entry available to decode stage.
REQ-013 out_ready  in  1  decode accepts head; pop when out_valid & out_ready.
REQ-014 out_ir  out  32  head instruction word.
REQ-015 out_npc  out  32  head fetch address + 1.

Function
REQ-016 At most one request outstanding; response latency is at least 1 cycle and unbounded.
REQ-017 FSM states: IDLE (no request outstanding), WAIT (outstanding, keep data), DROP (outstanding, discard data).
REQ-018 IDLE->WAIT: issue imem_req with imem_addr=pc when halt=0, redirect_valid=0, and count+0 < DEPTH (slot reserved at issue); pc <= pc+1.
REQ-019 WAIT->IDLE on imem_rvalid: push {imem_rdata, fetch addr+1} into the queue; entry is visible (out_valid=1) in the cycle after the rvalid edge.
REQ-020 A request is never issued in the same cycle a response is accepted; minimum issue interval is 2 cycles.
REQ-021 Queue full (count=DEPTH) suppresses issue; no overflow is possible, because of the reservation in REQ-018.
REQ-022 Push and pop in the same cycle: count is unchanged, and both take effect.
REQ-023 redirect_valid: queue is emptied (out_valid=0 next cycle), pc <= redirect_pc, and an in-flight pop is cancelled; redirect has priority over push, pop and issue.
REQ-024 Redirect while in WAIT -> DROP; in DROP, the response is discarded, then DROP->IDLE.
REQ-025 Redirect in the same cycle as imem_rvalid: the response is discarded, the state goes to IDLE, and pc <= redirect_pc.
REQ-026 Redirect while in DROP: pc is updated, and the state stays DROP.
REQ-027 First request after a redirect is issued no earlier than the cycle after the redirect, from IDLE.
REQ-028 halt=1: an outstanding response is still pushed, and the queue keeps draining. When halt falls, issue resumes from the current pc.
REQ-029 pc arithmetic is modulo 2^32; 32'hFFFFFFFF + 1 wraps to 32'h0, and out_npc wraps likewise.
REQ-030 out_ir and out_npc are don't-care when out_valid=0, but are held stable while out_valid=1 and out_ready=0.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=RESET_PC, count=0, read/write pointers=0, imem_req=0, imem_addr=0, out_valid=0, out_ir=0, out_npc=0.
REQ-032 Reset asserted mid-transaction abandons the request; a late imem_rvalid after reset release while in IDLE is ignored.
REQ-033 First imem_req occurs on the first posedge clk1 after rst_n rises, with imem_addr=RESET_PC.

Structure
REQ-034 Shared package mips32_pkg holds: word width 32, opcode constants (ADD..BEQZ, HLT), instruction-type encodings, and the fetch FSM state enum.
REQ-035 One sub-module, mips32_fetch_fifo: DEPTH-entry, 64-bit-wide synchronous FIFO with push, pop, flush, count, and asynchronous active-low reset.
REQ-036 Top-level holds the pc register, the FSM, and the reservation logic; no combinational path from imem_rvalid to imem_req.

Verification
REQ-037 Reset release, memory latency 1, out_ready=1 -> imem_addr 0,1,2,... every 2 cycles; out_ir matches Mem[n]; out_npc=n+1.
REQ-038 out_ready=0, DEPTH=4 -> exactly 4 requests then issue stops; count=4; raising out_ready drains the queue in order, then issue resumes.
REQ-039 Redirect to 32'h40 while a latency-3 request is outstanding -> that response is dropped, queue empty next cycle, next imem_addr=32'h40.
REQ-040 Redirect coincident with imem_rvalid and a pop -> no push, no pop counted, out_valid=0 next cycle, next fetch from redirect_pc.
REQ-041 halt raised with one request outstanding -> that instruction appears on out_ir, then no further imem_req until halt falls, then resumes at the next sequential pc.
REQ-042 RESET_PC=32'hFFFFFFFF -> first imem_addr=32'hFFFFFFFF with out_npc=32'h0, next imem_addr=32'h0; rst_n pulsed mid-WAIT -> outputs return to reset values immediately.
